// File: rtl/mem_port_pkg.sv
// Shared types and constants for the memory-port arbiter slice.
// Ports: none (package only).
// Provides the FSM state enum, the transaction owner enum, the
// alignment mask and the latency counter width.
package mem_port_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2,
    DONE    = 2'd3
  } state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  localparam logic [1:0] MEM_ALIGN_MASK = 2'b11;

  // Read latency is at most 15, so a 4-bit counter is enough.
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter that times the memory read latency.
// Latency: load takes effect at the next edge; expire_o is combinational from the count.
// Backpressure: none; the counter runs down freely once loaded and parks at 0.
// Ports: clk_i, rst_i (async active-high), load_i / load_val_i (load request and value),
//        value_o (current count), expire_o (count == 1, i.e. last wait cycle).
module mem_lat_counter
  import mem_port_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] value_o,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o  = cnt_q;
  assign expire_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store (data wins ties).
// Latency: load/fetch done in cycle READ_LATENCY+1 after accept, store done in cycle 2.
// Backpressure: requests are held high until done; the loser simply waits in IDLE.
// Ports: Clk, Reset_signal (async active-high); ifetch_req/addr -> ifetch_done/rdata;
//        data_req/we/addr/wdata -> data_done/rdata/err; mem_addr/wdata/wr out, mem_rdata in; busy.
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned requests complete immediately
// without touching memory (data side also flags data_err). Undefined: no check, data_err=0.
module mem_port_arbiter
  import mem_port_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32
) (
  input  logic              Clk,
  input  logic              Reset_signal,
  input  logic              ifetch_req,
  input  logic [ADDR_W-1:0] ifetch_addr,
  output logic              ifetch_done,
  output logic [DATA_W-1:0] ifetch_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_done,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] RL_CNT = CNT_W'(READ_LATENCY);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_wr_q, mem_wr_d;
  logic              ifetch_done_q, ifetch_done_d;
  logic              data_done_q, data_done_d;
  logic              data_err_q, data_err_d;
  logic [DATA_W-1:0] ifetch_rdata_q, ifetch_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_value;
  logic              cnt_expire;

  // Candidate request as seen in IDLE: data has fixed priority over fetch.
  logic              acc_data;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic              misaligned;

  assign acc_data = data_req;
  assign acc_we   = data_req & data_we;
  assign acc_addr = data_req ? data_addr : ifetch_addr;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (acc_addr[1:0] & MEM_ALIGN_MASK) != 2'b00;
`else
  // No check: every address goes to memory, so data_err can never be set.
  assign misaligned = 1'b0;
`endif

  mem_lat_counter u_lat_cnt (
    .clk_i      (Clk),
    .rst_i      (Reset_signal),
    .load_i     (cnt_load),
    .load_val_i (RL_CNT),
    .value_o    (cnt_value),
    .expire_o   (cnt_expire)
  );

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_wr_d       = 1'b0;
    ifetch_done_d  = 1'b0;
    data_done_d    = 1'b0;
    data_err_d     = 1'b0;
    ifetch_rdata_d = ifetch_rdata_q;
    data_rdata_d   = data_rdata_q;
    cnt_load       = 1'b0;

    case (state_q)
      IDLE: begin
        if (data_req || ifetch_req) begin
          owner_d = acc_data ? OWN_DATA : OWN_FETCH;
          if (misaligned) begin
            // No memory access at all; complete in the very next cycle.
            state_d = DONE;
            if (acc_data) begin
              data_done_d = 1'b1;
              data_err_d  = 1'b1;
            end else begin
              ifetch_done_d = 1'b1;
            end
          end else begin
            mem_addr_d = acc_addr;
            if (acc_we) begin
              mem_wdata_d = data_wdata;
              mem_wr_d    = 1'b1;
              state_d     = WR;
            end else begin
              cnt_load = 1'b1;
              state_d  = RD_WAIT;
            end
          end
        end
      end

      RD_WAIT: begin
        // A zero count only happens with an out-of-range latency parameter;
        // leaving on it keeps the FSM from waiting forever.
        if (cnt_expire || (cnt_value == '0)) begin
          state_d = DONE;
          if (owner_q == OWN_DATA) begin
            data_rdata_d = mem_rdata;
            data_done_d  = 1'b1;
          end else begin
            ifetch_rdata_d = mem_rdata;
            ifetch_done_d  = 1'b1;
          end
        end
      end

      WR: begin
        state_d = DONE;
        if (owner_q == OWN_DATA) begin
          data_done_d = 1'b1;
        end else begin
          ifetch_done_d = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset_signal) begin
    if (Reset_signal) begin
      state_q        <= IDLE;
      owner_q        <= OWN_FETCH;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_wr_q       <= 1'b0;
      ifetch_done_q  <= 1'b0;
      data_done_q    <= 1'b0;
      data_err_q     <= 1'b0;
      ifetch_rdata_q <= '0;
      data_rdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_wr_q       <= mem_wr_d;
      ifetch_done_q  <= ifetch_done_d;
      data_done_q    <= data_done_d;
      data_err_q     <= data_err_d;
      ifetch_rdata_q <= ifetch_rdata_d;
      data_rdata_q   <= data_rdata_d;
    end
  end

  assign ifetch_done  = ifetch_done_q;
  assign ifetch_rdata = ifetch_rdata_q;
  assign data_done    = data_done_q;
  assign data_rdata   = data_rdata_q;
  assign data_err     = data_err_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_wr       = mem_wr_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Sequences the single shared memory port between the instruction-fetch requester and the load/store data requester of the multicycle core. It absorbs the memory's fixed read latency so Control raises one request and waits for a done pulse instead of stepping through hard-coded delay states. Sits between Control/datapath and the memory; owns mem address, write data and write strobe.

Parameters:
READ_LATENCY, 2, memory read latency in cycles (legal 1..15)
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
Clk  in  1  clock
Reset_signal  in  1  reset; one clock; reset is asynchronous and active-high
ifetch_req  in  1  fetch request, held until ifetch_done
ifetch_addr  in  ADDR_W  fetch address (PC)
ifetch_done  out  1  one-cycle completion pulse, fetch
ifetch_rdata  out  DATA_W  fetched word, valid from ifetch_done until the next fetch completes
data_req  in  1  load/store request, held until data_done
data_we  in  1  1=store, 0=load
data_addr  in  ADDR_W  load/store address
data_wdata  in  DATA_W  store data
data_done  out  1  one-cycle completion pulse, data
data_rdata  out  DATA_W  loaded word, valid from data_done until the next load completes
data_err  out  1  misalignment flag (see Optional Feature)
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wr  out  1  memory write strobe, 1=write
mem_rdata  in  DATA_W  memory read data
busy  out  1  transaction in progress (state != IDLE)

Behaviour:
- All outputs registered. Reset value of every output is 0. State after reset is IDLE.
- States: IDLE, RD_WAIT, WR, DONE.
- IDLE, arbitration at each edge:
  - Fixed priority: data over fetch.
  - On accept: latch owner, we, addr and wdata. Drive mem_addr (and mem_wdata for a store) from the latched values.
  - Load or fetch goes to RD_WAIT with cnt=READ_LATENCY. Store goes to WR.
- Numbering: cycle 1 is the cycle after the accepting edge.
- RD_WAIT:
  - cnt decrements each edge.
  - At the edge where cnt==1, capture mem_rdata into the owner's rdata register and go to DONE.
  - Read: cycles 1..READ_LATENCY in RD_WAIT; owner done=1 in cycle READ_LATENCY+1.
- WR: mem_wr=1 in cycle 1 only, then DONE. Store done=1 in cycle 2.
- DONE: owner's done=1 for exactly one cycle, then IDLE. mem_wr=0. mem_addr holds its last value.
- The requester must drop req at the edge ending its done cycle. A req still high in IDLE is a new transaction.
- A request is never aborted by its requester. Dropping req mid-transaction still completes the transaction and still pulses done.
- The losing requester's req is simply not accepted. It is served from IDLE after the winner's DONE, giving no back-to-back starvation of fetch by a single data access.
- The non-owner's rdata register is never modified.
- Reset mid-operation:
  - Immediate return to IDLE; mem_wr drops asynchronously.
  - No done pulse for the aborted transaction.
  - rdata registers cleared to 0.
- Width: cnt is 4 bits. No arithmetic on the data path; addresses pass through unchanged.

Optional Feature:
MEM_ALIGN_CHECK_EN
- Defined:
  - An accepted request with addr[1:0]!=0 produces no memory access: mem_wr stays 0 and mem_addr is unchanged.
  - The state machine goes directly IDLE->DONE.
  - Owner done=1 in cycle 1.
  - For a data owner, data_err=1 in the same cycle; a fetch misalignment pulses ifetch_done only.
  - rdata is unchanged.
- Undefined: data_err is tied to 0, and every address is passed to memory unchanged.

Decomposition:
- Package mem_port_pkg:
  - state enum {IDLE, RD_WAIT, WR, DONE}
  - owner enum {OWN_FETCH, OWN_DATA}
  - MEM_ALIGN_MASK constant (2'b11)
- One sub-module, mem_lat_counter:
  - loadable down-counter with load, value and expire outputs
  - reset to 0

Test Plan:
- Fetch read:
  - Stimulus: ifetch_req=1, ifetch_addr=0x0000_0004, memory returns 0xDEADBEEF, READ_LATENCY=2.
  - Response: mem_addr=0x4 in cycles 1-2; ifetch_done=1 in cycle 3 only; ifetch_rdata=0xDEADBEEF; mem_wr never 1.
- Store:
  - Stimulus: data_req=1, data_we=1, addr=0x10, wdata=0x12345678.
  - Response: mem_wr=1 only in cycle 1 with mem_addr=0x10 and mem_wdata=0x12345678; data_done=1 in cycle 2; busy=0 in cycle 3.
- Collision:
  - Stimulus: data_req (load 0x20) and ifetch_req (0x8) rise on the same edge.
  - Response: load served first with data_done in cycle 3; fetch accepted after IDLE, with ifetch_done 4 cycles later; data_rdata and ifetch_rdata each hold their own word.
- Reset mid-read:
  - Stimulus: Reset_signal pulsed during cycle 2 of a fetch.
  - Response: all outputs 0 immediately; no ifetch_done; a subsequent fetch completes normally in 3 cycles.
- Misaligned access:
  - Stimulus: data_req load at addr 0x6.
  - Response with MEM_ALIGN_CHECK_EN: data_done=1 and data_err=1 in cycle 1, no memory access.
  - Response without: normal load with mem_addr=0x6 and data_err=0.
- READ_LATENCY=1:
  - Stimulus: fetch at 0x0.
  - Response: ifetch_done in cycle 2.
